// File: rtl/jk_latch_stim_checker.sv
// -----------------------------------------------------------------------------
// jk_latch_stim_checker
//
// Stimulus and checking stage for a pair of JK latch implementations that are
// compared against each other. It drives a shared latch enable (c) and J/K
// inputs: a clear vector first, then LFSR-generated vectors. Each vector takes
// four cycles (SETUP, ENABLE, HOLD, CHECK), and c is high only in ENABLE. In
// CHECK both latch pairs are compared against a cycle-accurate JK golden value.
// The block reports the vector count, a saturating mismatch count and the index
// of the first failing vector.
//
// Ports:
//   clk              in   rising-edge system clock
//   rst              in   asynchronous active-high reset
//   i_start          in   run request; only looked at in IDLE and DONE
//   i_q1, i_nq1      in   outputs of latch implementation 1
//   i_q2, i_nq2      in   outputs of latch implementation 2
//   o_c              out  latch enable to both implementations
//   o_j, o_k         out  latch data inputs to both implementations
//   o_busy           out  high from the first SETUP to the last CHECK
//   o_done           out  high in DONE
//   o_fail           out  sticky, set by the first mismatch of a run
//   o_vec_cnt        out  vectors completed in this run
//   o_mismatch_cnt   out  failing vectors, saturates at 16'hFFFF
//   o_first_fail_idx out  index of the first failing vector, 16'hFFFF if none
// -----------------------------------------------------------------------------
module jk_latch_stim_checker #(
  parameter int unsigned N_VECTORS    = 256,
  parameter logic [7:0]  SEED         = 8'hA5,
  parameter bit          ALLOW_TOGGLE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_q1,
  input  logic        i_nq1,
  input  logic        i_q2,
  input  logic        i_nq2,
  output logic        o_c,
  output logic        o_j,
  output logic        o_k,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fail,
  output logic [15:0] o_vec_cnt,
  output logic [15:0] o_mismatch_cnt,
  output logic [15:0] o_first_fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ENABLE,
    S_HOLD,
    S_CHECK,
    S_DONE
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is loaded as 1.
  localparam logic [7:0]  LOAD_SEED = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0] LAST_CNT  = 16'(N_VECTORS);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_c;
  logic        r_j;
  logic        r_k;
  logic        r_busy;
  logic        r_done;
  logic        r_fail;
  logic [15:0] r_vec_cnt;
  logic [15:0] r_mismatch_cnt;
  logic [15:0] r_first_fail_idx;
  logic [7:0]  r_lfsr;
  logic        r_exp;

  logic        w_start_run;
  logic        w_exp_next;
  logic        w_vec_fail;
  logic [7:0]  w_lfsr_next;
  logic [15:0] w_vec_cnt_inc;
  logic        w_last_vec;
  logic        w_gen_j;
  logic        w_gen_k;

  assign w_start_run   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_vec_cnt_inc = r_vec_cnt + 16'd1;
  assign w_last_vec    = (w_vec_cnt_inc == LAST_CNT);

  // Fibonacci LFSR, taps 8,6,5,4.
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // The next vector's J/K are taken from the post-step LFSR so they can be
  // registered on the same edge that enters SETUP. Without toggle support a
  // J=K=1 pair is turned into a set, so a transparent latch cannot oscillate.
  assign w_gen_j = w_lfsr_next[0];
  assign w_gen_k = (ALLOW_TOGGLE || !w_gen_j) ? w_lfsr_next[1] : 1'b0;

  // Golden JK value after this vector's enable pulse.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_exp_next = r_exp;
    case ({r_j, r_k})
      2'b10:   w_exp_next = 1'b1;
      2'b01:   w_exp_next = 1'b0;
      2'b11:   w_exp_next = ~r_exp;
      default: w_exp_next = r_exp;
    endcase
  end

  assign w_vec_fail = (i_q1 != w_exp_next) || (i_q2 != w_exp_next) ||
                      (i_nq1 == i_q1)      || (i_nq2 == i_q2);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples the values from before this edge.
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_next = S_SETUP;
      S_SETUP:  w_state_next = S_ENABLE;
      S_ENABLE: w_state_next = S_HOLD;
      S_HOLD:   w_state_next = S_CHECK;
      S_CHECK:  w_state_next = w_last_vec ? S_DONE : S_SETUP;
      S_DONE:   if (i_start) w_state_next = S_SETUP;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Registered outputs and run datapath. The asynchronous reset also pulls
  // c low immediately when a run is abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c              <= 1'b0;
      r_j              <= 1'b0;
      r_k              <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_fail           <= 1'b0;
      r_vec_cnt        <= 16'd0;
      r_mismatch_cnt   <= 16'd0;
      r_first_fail_idx <= 16'hFFFF;
      r_lfsr           <= SEED;
      r_exp            <= 1'b0;
    end else begin
      // SETUP always leads to ENABLE, so c is high for exactly that cycle.
      r_c <= (r_state == S_SETUP);

      if (w_start_run) begin
        r_lfsr           <= LOAD_SEED;
        r_exp            <= 1'b0;
        r_vec_cnt        <= 16'd0;
        r_mismatch_cnt   <= 16'd0;
        r_fail           <= 1'b0;
        r_first_fail_idx <= 16'hFFFF;
        r_done           <= 1'b0;
        r_busy           <= 1'b1;
        // Vector 0 clears both latches.
        r_j              <= 1'b0;
        r_k              <= 1'b1;
      end else if (r_state == S_CHECK) begin
        r_exp     <= w_exp_next;
        r_vec_cnt <= w_vec_cnt_inc;
        r_lfsr    <= w_lfsr_next;

        if (w_vec_fail) begin
          if (r_mismatch_cnt != 16'hFFFF) begin
            r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
          end
          if (!r_fail) begin
            r_fail           <= 1'b1;
            r_first_fail_idx <= r_vec_cnt;
          end
        end

        if (w_last_vec) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_j <= w_gen_j;
          r_k <= w_gen_k;
        end
      end
    end
  end

  assign o_c              = r_c;
  assign o_j              = r_j;
  assign o_k              = r_k;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_fail           = r_fail;
  assign o_vec_cnt        = r_vec_cnt;
  assign o_mismatch_cnt   = r_mismatch_cnt;
  assign o_first_fail_idx = r_first_fail_idx;

endmodule

// File: tb/tb_jk_latch_stim_checker.sv
// -----------------------------------------------------------------------------
// tb_jk_latch_stim_checker
//
// Two checker instances share clk/rst: instance 0 (16 vectors, seed A5, no
// toggle) and instance 1 (12 vectors, seed 00, toggle allowed). Each drives an
// ideal behavioural JK latch; per-vector fault kinds can corrupt the latch
// outputs seen by the checker. A reference model recomputes the J/K sequence
// and the expected counters from the rules of the block.
// -----------------------------------------------------------------------------
module tb_jk_latch_stim_checker;

  localparam int         LOG    = 1024;
  localparam int         NV [2] = '{16, 12};
  localparam logic [7:0] SD [2] = '{8'hA5, 8'h00};
  localparam bit         TG [2] = '{1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start_s = 2'b00;
  logic [3:0]  drv [2];   // {q1, nq1, q2, nq2}
  logic [1:0]  c_s, j_s, k_s, busy_s, done_s, fail_s;
  logic [15:0] vc_s [2];
  logic [15:0] mm_s [2];
  logic [15:0] ff_s [2];

  // Environment state (written by the monitor only).
  logic        lq [2]          = '{1'b0, 1'b0};
  int          pc [2]          = '{0, 0};
  int          viol [2]        = '{0, 0};
  int          cur_kind [2]    = '{0, 0};
  logic        prev_c [2]      = '{1'b0, 1'b0};
  logic [1:0]  prev_jk [2]     = '{2'b00, 2'b00};
  logic [1:0]  jk_log [2][LOG];

  // Written by the stimulus block only.
  int          base [2]        = '{0, 0};
  int          corrupt [2][64];

  // Reference model results.
  logic [1:0]  ref_jk [64];
  int          ref_mm;
  int          ref_ffi;

  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  jk_latch_stim_checker #(.N_VECTORS(16), .SEED(8'hA5), .ALLOW_TOGGLE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .i_start(start_s[0]),
    .i_q1(drv[0][3]), .i_nq1(drv[0][2]), .i_q2(drv[0][1]), .i_nq2(drv[0][0]),
    .o_c(c_s[0]), .o_j(j_s[0]), .o_k(k_s[0]),
    .o_busy(busy_s[0]), .o_done(done_s[0]), .o_fail(fail_s[0]),
    .o_vec_cnt(vc_s[0]), .o_mismatch_cnt(mm_s[0]), .o_first_fail_idx(ff_s[0])
  );

  jk_latch_stim_checker #(.N_VECTORS(12), .SEED(8'h00), .ALLOW_TOGGLE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .i_start(start_s[1]),
    .i_q1(drv[1][3]), .i_nq1(drv[1][2]), .i_q2(drv[1][1]), .i_nq2(drv[1][0]),
    .o_c(c_s[1]), .o_j(j_s[1]), .o_k(k_s[1]),
    .o_busy(busy_s[1]), .o_done(done_s[1]), .o_fail(fail_s[1]),
    .o_vec_cnt(vc_s[1]), .o_mismatch_cnt(mm_s[1]), .o_first_fail_idx(ff_s[1])
  );

  // Fault kinds: 0 none, 1 q1 flipped, 2 q2 flipped, 3 nq1 tied to q1,
  // 4 nq2 tied to q2, 5 q2 stuck at 1 (nq2 stuck at 0).
  function automatic logic [3:0] drive(input logic q, input int kind);
    case (kind)
      1:       return {~q, q, q, ~q};
      2:       return {q, ~q, ~q, q};
      3:       return {q, q, q, ~q};
      4:       return {q, ~q, q, q};
      5:       return {q, ~q, 1'b1, 1'b0};
      default: return {q, ~q, q, ~q};
    endcase
  endfunction

  function automatic logic jk_rule(input logic q, input logic j, input logic k);
    if (j && !k) return 1'b1;
    if (!j && k) return 1'b0;
    if (j && k)  return ~q;
    return q;
  endfunction

  assign drv[0] = drive(lq[0], cur_kind[0]);
  assign drv[1] = drive(lq[1], cur_kind[1]);

  // Ideal latches plus J/K stability monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        prev_c[i] <= 1'b0;
      end else begin
        if (c_s[i] && prev_c[i]) viol[i] <= viol[i] + 1;
        if (prev_c[i] && ({j_s[i], k_s[i]} != prev_jk[i])) viol[i] <= viol[i] + 1;
        if (c_s[i]) begin
          lq[i]                 <= jk_rule(lq[i], j_s[i], k_s[i]);
          jk_log[i][pc[i] % LOG] <= {j_s[i], k_s[i]};
          cur_kind[i]           <= ((pc[i] - base[i]) >= 0 && (pc[i] - base[i]) < 64)
                                   ? corrupt[i][pc[i] - base[i]] : 0;
          pc[i]                 <= pc[i] + 1;
        end
        prev_c[i]  <= c_s[i];
        prev_jk[i] <= {j_s[i], k_s[i]};
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: J/K per vector, then the golden value and fault outcome.
  function automatic void ref_run(input int i);
    logic [7:0] l;
    logic       e, en, j, k, bad;
    l       = (SD[i] == 8'h00) ? 8'h01 : SD[i];
    e       = 1'b0;
    ref_mm  = 0;
    ref_ffi = 32'hFFFF;
    for (int n = 0; n < NV[i]; n++) begin
      if (n == 0) begin
        j = 1'b0; k = 1'b1;
      end else begin
        j = l[0]; k = l[1];
        if (j && k && !TG[i]) k = 1'b0;
      end
      ref_jk[n] = {j, k};
      en  = jk_rule(e, j, k);
      bad = (corrupt[i][n] >= 1 && corrupt[i][n] <= 4) || (corrupt[i][n] == 5 && !en);
      if (bad) begin
        if (ref_mm == 0) ref_ffi = n;
        ref_mm++;
      end
      e = en;
      l = (l << 1) | 8'(^(l & 8'hB8));
    end
  endfunction

  task automatic set_faults(input int i, input int mode, input int from);
    for (int v = 0; v < 64; v++) begin
      if (mode < 0) corrupt[i][v] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      else          corrupt[i][v] = (v >= from) ? mode : 0;
    end
  endtask

  task automatic check_reset(input int g, input string tag);
    check({tag, "/c"},    c_s[g],    0);
    check({tag, "/jk"},   {j_s[g], k_s[g]}, 0);
    check({tag, "/busy"}, busy_s[g], 0);
    check({tag, "/done"}, done_s[g], 0);
    check({tag, "/fail"}, fail_s[g], 0);
    check({tag, "/vec"},  vc_s[g],   0);
    check({tag, "/mm"},   mm_s[g],   0);
    check({tag, "/ffi"},  ff_s[g],   32'hFFFF);
  endtask

  // Runs one full vector set; returns at the negedge where done is seen.
  task automatic do_run(input int g, input bit pre_started, input bit keep_start, input string tag);
    int k;
    int n11;
    if (!pre_started) begin
      start_s[g] = 1'b1;
      @(negedge clk);
    end
    base[g] = pc[g];
    if (!keep_start) start_s[g] = 1'b0;
    check({tag, "/busy_on"},  busy_s[g], 1);
    check({tag, "/done_off"}, done_s[g], 0);
    check({tag, "/vec_clr"},  vc_s[g],   0);
    check({tag, "/mm_clr"},   mm_s[g],   0);
    check({tag, "/fail_clr"}, fail_s[g], 0);
    check({tag, "/ffi_clr"},  ff_s[g],   32'hFFFF);
    check({tag, "/setup0"},   {c_s[g], j_s[g], k_s[g]}, 3'b001);
    k = 0;
    while (done_s[g] !== 1'b1 && k < 4 * NV[g] + 8) begin
      @(negedge clk);
      k++;
    end
    check({tag, "/latency"}, k, 4 * NV[g]);
    ref_run(g);
    check({tag, "/busy_end"}, busy_s[g], 0);
    check({tag, "/vec_cnt"},  vc_s[g],   NV[g]);
    check({tag, "/mm_cnt"},   mm_s[g],   ref_mm);
    check({tag, "/fail"},     fail_s[g], (ref_mm > 0) ? 1 : 0);
    check({tag, "/ffi"},      ff_s[g],   ref_ffi);
    check({tag, "/pulses"},   pc[g] - base[g], NV[g]);
    check({tag, "/jk_hold"},  viol[g], 0);
    n11 = 0;
    for (int n = 0; n < NV[g]; n++) begin
      check({tag, $sformatf("/jk%0d", n)}, jk_log[g][(base[g] + n) % LOG], ref_jk[n]);
      if (jk_log[g][(base[g] + n) % LOG] == 2'b11) n11++;
    end
    if (TG[g]) check({tag, "/toggle_seen"}, (n11 > 0) ? 1 : 0, 1);
  endtask

  initial begin
    set_faults(0, 0, 0);
    set_faults(1, 0, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset(0, "reset_a");
    check_reset(1, "reset_b");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Ideal latches.
    do_run(0, 1'b0, 1'b0, "ideal_a");
    check("ideal_a/mm_zero",  mm_s[0], 0);
    check("ideal_a/ffi_none", ff_s[0], 32'hFFFF);

    // q2 stuck at 1: the clear vector fails first.
    set_faults(0, 5, 0);
    do_run(0, 1'b0, 1'b0, "stuck_q2");
    check("stuck_q2/ffi0", ff_s[0], 0);

    // nq1 tied to q1 from vector 3 onward.
    set_faults(0, 3, 3);
    do_run(0, 1'b0, 1'b0, "nq1_tie");
    check("nq1_tie/ffi3", ff_s[0], 3);
    check("nq1_tie/mm13", mm_s[0], 13);

    // Randomised fault patterns with random idle gaps.
    for (int r = 0; r < 3; r++) begin
      set_faults(0, -1, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run(0, 1'b0, 1'b0, $sformatf("rand_a%0d", r));
    end

    // Reset during the ENABLE cycle of vector 5.
    set_faults(0, 0, 0);
    start_s[0] = 1'b1;
    @(negedge clk);
    base[0]    = pc[0];
    start_s[0] = 1'b0;
    repeat (21) @(negedge clk);
    check("rst_mid/c_high", c_s[0], 1);
    check("rst_mid/vec5",   vc_s[0], 5);
    #1 rst = 1'b1;
    #1 check_reset(0, "rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_run(0, 1'b0, 1'b0, "after_rst");

    // start held high: no restart while busy, restart right after DONE.
    set_faults(0, 3, 3);
    do_run(0, 1'b0, 1'b1, "held1");
    check("held1/mm13", mm_s[0], 13);
    set_faults(0, 0, 0);
    @(negedge clk);
    do_run(0, 1'b1, 1'b0, "held2");

    // Zero seed with toggle allowed.
    do_run(1, 1'b0, 1'b0, "toggle_b");
    check("toggle_b/mm_zero", mm_s[1], 0);
    set_faults(1, -1, 0);
    do_run(1, 1'b0, 1'b0, "rand_b");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_latch_stim_checker.md
# jk_latch_stim_checker

Self-checking stimulus stage that sits directly upstream of the two-implementation JK latch comparison pair. It drives the shared latch enable and J/K inputs with a reset vector followed by LFSR-generated vectors, pulses the enable for exactly one cycle per vector, and samples both latch pairs against a cycle-accurate JK golden model. It reports vector count, saturating mismatch count and the index of the first failing vector.

## Interface

Parameters:
- N_VECTORS, 256: total vectors per run including the initial clear vector; legal range 1..65535.
- SEED, 8'hA5: LFSR load value on start; 8'h00 is replaced by 8'h01.
- ALLOW_TOGGLE, 0: when 0, a generated J=K=1 is replaced by J=1,K=0, so a transparent latch never oscillates.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request, sampled in IDLE and DONE only.
- q1, nq1  in  1 each  outputs of latch implementation 1.
- q2, nq2  in  1 each  outputs of latch implementation 2.
- c  out  1  latch enable to both implementations.
- j, k  out  1 each  latch data inputs to both implementations.
- busy  out  1  high from the first SETUP to the last CHECK.
- done  out  1  high in DONE.
- fail  out  1  sticky; set on the first mismatch of a run.
- vec_cnt  out  16  vectors completed in this run.
- mismatch_cnt  out  16  failing vectors; saturates at 16'hFFFF.
- first_fail_idx  out  16  index of the first failing vector; 16'hFFFF if none.

## Operation

- States: IDLE, SETUP, ENABLE, HOLD, CHECK, DONE. Each non-idle state lasts one cycle, giving 4 cycles per vector.
- IDLE, or DONE with start=1: go to SETUP. On that transition:
  - load lfsr=SEED (0 replaced by 1) and set exp=0;
  - clear vec_cnt and mismatch_cnt, clear fail, set first_fail_idx=16'hFFFF;
  - drop done.
- SETUP: drive j,k with c=0.
  - Vector 0 is always J=0,K=1 (clear).
  - Vectors n≥1 use j=lfsr[0], k=lfsr[1], with the ALLOW_TOGGLE substitution applied.
- ENABLE: c=1, j,k unchanged.
- HOLD: c=0, j,k unchanged, giving the latches a settle cycle.
- CHECK: c=0, j,k unchanged. Sample the inputs and compute exp_next from the applied J/K:
  - 10 gives 1;
  - 01 gives 0;
  - 11 gives ~exp (reachable only with ALLOW_TOGGLE=1);
  - 00 gives exp.
- A vector fails if any of these holds: q1≠exp_next, q2≠exp_next, nq1≠~q1, nq2≠~q2.
- On failure:
  - mismatch_cnt increments, saturating;
  - if fail=0, set fail=1 and first_fail_idx=vec_cnt.
- Every CHECK also does the following:
  - exp ← exp_next;
  - vec_cnt increments;
  - lfsr steps once (Fibonacci, taps 8,6,5,4: new bit = l[7]^l[5]^l[4]^l[3], shifted into l[0]).
- After CHECK: if vec_cnt (post-increment) equals N_VECTORS, go to DONE. Otherwise go to SETUP.
- DONE: done=1, busy=0, c=0. Results hold until the next start.
- start is ignored while busy=1.

## Timing

- Reset (asynchronous, immediate) sets:
  - state IDLE;
  - c=0, j=0, k=0;
  - busy=0, done=0, fail=0;
  - vec_cnt=0, mismatch_cnt=0, first_fail_idx=16'hFFFF;
  - lfsr=SEED, exp=0.
- Reset mid-run abandons the run. c must drop to 0 asynchronously in the same instant.
- All outputs are registered. No combinational path from q*/nq* to any output.
- Latency:
  - start sampled at edge t gives busy=1 after t;
  - vector n's c pulse occupies the cycle after edge t+4n+1;
  - its CHECK sample is at edge t+4n+4;
  - done=1 after edge t+4·N_VECTORS.
- c is high for exactly one clock per vector. j/k never change in the cycle c is high or the cycle after.
- The counter updates of the final CHECK are visible in the same cycle done rises.

## Test plan

- Ideal latch model on both inputs, N_VECTORS=16, SEED=8'hA5 → done after 64 cycles; vec_cnt=16, mismatch_cnt=0, fail=0, first_fail_idx=16'hFFFF. c is high in exactly 16 cycles, never with j=k=1.
- q2 stuck at 1, N_VECTORS=8 → vector 0 (clear) fails. Result: fail=1, first_fail_idx=0, mismatch_cnt equals the count of vectors whose exp_next=0 (vector 0 included).
- nq1 tied to q1 from vector 3 onward, N_VECTORS=8 → first_fail_idx=3, mismatch_cnt=5.
- Assert rst during the ENABLE of vector 5 → c=0 immediately; all outputs return to reset values. A new start reproduces the identical j/k sequence from vector 0.
- SEED=8'h00, ALLOW_TOGGLE=1, ideal model → LFSR loads 8'h01 and J=K=1 vectors appear; the expected value toggles on them, with zero mismatches.
- start held high throughout a run → no restart while busy. A new run begins on the cycle after DONE is entered, with counters cleared.
